// File: rtl/apb_fifo_slave_if.sv
// APB bus bundle between the master's decoded slot and the FIFO mailbox responder.
// The level interrupt is a sideband output of the responder, not part of this bundle.
interface apb_fifo_slave_if;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWRITE, PENABLE, PSEL, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PENABLE, PSEL, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_fifo_slave.sv
// APB responder exposing an 8-bit software mailbox FIFO with programmable wait states,
// sticky overflow/underflow flags and a level interrupt.
module apb_fifo_slave #(
    parameter int DEPTH       = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_fifo_slave_if.slave     bus,
    output logic                irq
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [3:0]  WAIT_C  = 4'(WAIT_CYCLES);

    localparam logic [9:0] OFF_CTRL   = 10'h000;
    localparam logic [9:0] OFF_STATUS = 10'h001;
    localparam logic [9:0] OFF_TXDATA = 10'h002;
    localparam logic [9:0] OFF_RXDATA = 10'h003;

    // Handshake: a transfer is SETUP (PSEL & ~PENABLE) then ACCESS (PSEL & PENABLE);
    // ACCESS holds while PREADY is low, and the cycle with ACCESS & PREADY is the single
    // completion cycle whose closing edge commits every side effect exactly once.
    logic        access;
    logic        complete;
    logic        wr_done;
    logic        rd_done;
    logic [9:0]  reg_off;

    logic [3:0]  wcnt;
    logic        abort;

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic        en;
    logic        ovf;
    logic        udf;
    logic        empty;
    logic        full;

    logic        do_push;
    logic        do_pop;
    logic        do_clr;
    logic [31:0] rdata;

    assign access   = bus.PSEL & bus.PENABLE;
    assign bus.PREADY = access & ~abort & (wcnt == WAIT_C);
    assign complete = access & bus.PREADY;
    assign wr_done  = complete & bus.PWRITE;
    assign rd_done  = complete & ~bus.PWRITE;
    assign reg_off  = bus.PADDR[11:2];

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign irq   = en & ~empty;

    assign do_clr  = wr_done & (reg_off == OFF_CTRL) & bus.PWDATA[1];
    assign do_push = wr_done & (reg_off == OFF_TXDATA) & en & ~full;
    assign do_pop  = rd_done & (reg_off == OFF_RXDATA) & en & ~empty;

    logic unused_bits;
    assign unused_bits = ^{bus.PADDR[31:12], bus.PADDR[1:0], bus.PWDATA[31:8]};

    // A transfer caught by reset stays dead until the master leaves ACCESS.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            wcnt  <= '0;
            abort <= 1'b1;
        end else begin
            if (!access)
                abort <= 1'b0;
            if (!access || complete || abort)
                wcnt <= '0;
            else
                wcnt <= wcnt + 4'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (do_push)
            mem[wptr] <= bus.PWDATA[7:0];
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            en    <= 1'b0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (wr_done && reg_off == OFF_CTRL)
                en <= bus.PWDATA[0];
            if (wr_done && reg_off == OFF_STATUS) begin
                if (bus.PWDATA[2]) ovf <= 1'b0;
                if (bus.PWDATA[3]) udf <= 1'b0;
            end
            if (wr_done && reg_off == OFF_TXDATA && en && full)
                ovf <= 1'b1;
            if (rd_done && reg_off == OFF_RXDATA && en && empty)
                udf <= 1'b1;

            if (do_clr) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (do_push) begin
                    wptr  <= wptr + 1'b1;
                    count <= count + 1'b1;
                end
                if (do_pop) begin
                    rptr  <= rptr + 1'b1;
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_off)
            OFF_CTRL:   rdata = {31'b0, en};
            OFF_STATUS: rdata = {16'b0, 8'(count), 4'b0, udf, ovf, full, empty};
            OFF_RXDATA: rdata = (en && !empty) ? {24'b0, mem[rptr]} : 32'b0;
            default:    rdata = '0;
        endcase
    end

    assign bus.PRDATA = rd_done ? rdata : 32'b0;
endmodule

// File: doc/apb_fifo_slave.md
Name: apb_fifo_slave

Overview:
- APB responder peripheral for one 4 KB slot behind the APB master's PSELx decode (e.g. 0x1000_2000 region); only PADDR[11:0] is used.
- Provides a software mailbox: a DEPTH-entry, 8-bit FIFO pushed and popped through memory-mapped registers.
- Supports programmable wait states via PREADY, sticky error flags and a level interrupt.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..128.
- WAIT_CYCLES, 1, number of PREADY-low cycles inserted in each ACCESS phase (0..15).

Ports:
- PCLK  in  1  clock; all logic is on the rising edge.
- PRESET  in  1  synchronous, active-low reset.
- PADDR  in  32  address; bits [11:2] decoded, [1:0] ignored.
- PWRITE  in  1  1 = write, 0 = read.
- PENABLE  in  1  ACCESS phase marker.
- PSEL  in  1  slot select from the master's decoder.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer completion.
- irq  out  1  level: CTRL.en & ~empty.

Behaviour:
- Reset: PRESET low at a PCLK edge clears pointers, count, CTRL, flags and the wait counter. PREADY=0, PRDATA=0, irq=0 the following cycle.
- Register map:
  - 0x00 CTRL (RW): bit0 en; bit1 clr, write-only pulse that reads as 0.
  - 0x04 STATUS (RO except W1C):
    - bit0 empty, bit1 full, bit2 ovf, bit3 udf.
    - [15:8] count.
    - Writing 1 to bit2/bit3 clears that flag.
  - 0x08 TXDATA (WO): write pushes PWDATA[7:0]; reads return 0.
  - 0x0C RXDATA (RO): read pops and returns {24'b0, head}; writes are ignored.
  - Other offsets: read 0, write no effect; PREADY is still returned normally.
- Handshake:
  - SETUP = PSEL & ~PENABLE.
  - ACCESS = PSEL & PENABLE.
  - The wait counter is 0 outside ACCESS and increments on each ACCESS cycle while PREADY=0.
  - PREADY = ACCESS & (wcnt == WAIT_CYCLES). With WAIT_CYCLES=0 this means PREADY is high in the first ACCESS cycle (combinational from PSEL/PENABLE/counter).
  - Completion cycle C = ACCESS & PREADY. All side effects (register write, push, pop, W1C) commit exactly once, at the edge ending C. The counter returns to 0 after C.
  - PRDATA is driven with read data only during C of a read; it is 0 at all other times.
  - PREADY is 0 whenever PSEL=0.
- FIFO:
  - Circular buffer with wptr/rptr of log2(DEPTH) bits that wrap DEPTH-1 -> 0; count is 0..DEPTH.
  - empty = (count==0); full = (count==DEPTH).
- Boundaries:
  - Push while full: data dropped, pointers unchanged, ovf <= 1.
  - Pop while empty: PRDATA=0, rptr unchanged, udf <= 1.
  - en=0: push/pop are ignored, no flags are set, the RXDATA read returns 0, and irq=0.
  - clr write: pointers and count <= 0, flags untouched, data RAM contents don't-care.
  - CTRL write with en=1 and clr=1 flushes and enables in the same edge.
  - RXDATA read returns the head value before the pop; the pop takes effect at that same edge.
  - A W1C write and a new error cannot coincide, because only one APB transfer is active at a time.
  - Reset asserted mid-transfer: transfer aborted, no side effect; PREADY=0 from the next cycle.
  - PSEL dropped before PREADY: wait counter cleared, no side effect.

Test Plan:
- Reset, then read STATUS at 0x04 -> PRDATA=0x0000_0001 (empty), irq=0; with WAIT_CYCLES=1, PREADY is low for exactly one ACCESS cycle.
- Write CTRL=0x1, push 0xA5 then 0x3C -> STATUS=0x0000_0200, irq=1; RXDATA reads 0x0000_00A5 then 0x0000_003C; STATUS=0x01, irq drops 1 cycle after the last pop.
- Push 9 values 0x10..0x18 with DEPTH=8 -> STATUS=0x0000_0806 (full, ovf); pops return 0x10..0x17; write STATUS=0x4 -> ovf clears.
- Pop with FIFO empty -> PRDATA=0, STATUS bit3=1; 20 push/pop pairs with value i -> each pop returns i (pointer wrap), count stays ≤1.
- CTRL=0x0, then push 0x77 -> count stays 0, no flags; CTRL=0x3 after 3 pushes -> count=0, en=1.
- Assert PRESET=0 during the ACCESS wait cycle of a TXDATA write -> no push; PREADY=0, PRDATA=0 on the next cycle; STATUS reads 0x1 after release.
